frame_recycler: RTL and testbench

FRAME_RECYCLER -- requirements
Module: frame_recycler

---
 rtl/frame_recycler.sv | 146 ++++++++++++++
 tb/tb_frame_recycler.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_recycler.sv
// Frame recycler: stores one input frame of vectors and replays it NUM_PASSES
// times as sliding windows of FILTER_LEN consecutive vectors.
module frame_recycler #(
  parameter int BW         = 8,
  parameter int VECTOR_LEN = 13,
  parameter int FRAME_LEN  = 50,
  parameter int FILTER_LEN = 3,
  parameter int NUM_PASSES = 8,
  localparam int VECTOR_BW = VECTOR_LEN * BW,
  localparam int PASS_BW   = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1
) (
  input  logic                            clk_i,
  input  logic                            rst_n_i,
  input  logic [VECTOR_BW-1:0]            data_i,
  input  logic                            valid_i,
  input  logic                            last_i,
  output logic                            ready_o,
  output logic [FILTER_LEN*VECTOR_BW-1:0] data_o,
  output logic                            valid_o,
  input  logic                            ready_i,
  output logic [PASS_BW-1:0]              pass_idx_o,
  output logic                            pass_last_o,
  output logic                            last_o,
  output logic                            err_short_o,
  output logic                            err_ovf_o,
  output logic [1:0]                      dbg_state_o
);

  // Handshakes: a beat moves on valid_i & ready_o, a window on valid_o & ready_i,
  // both sampled at the rising edge; neither valid depends on the matching ready.

  localparam int CNT_BW = $clog2(FRAME_LEN + 1);
  localparam int IDX_BW = $clog2(FRAME_LEN);

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    DRAIN  = 2'd1,
    REPLAY = 2'd2
  } state_t;

  state_t               state_q;
  logic [CNT_BW-1:0]    wr_cnt_q;
  logic [CNT_BW-1:0]    len_q;
  logic [CNT_BW-1:0]    win_q;
  logic [PASS_BW-1:0]   pass_q;
  logic                 err_short_q;
  logic                 err_ovf_q;
  logic [VECTOR_BW-1:0] buf_q [FRAME_LEN];

  logic [CNT_BW-1:0] wr_next;
  logic [CNT_BW-1:0] last_win;
  logic              at_last_win;
  logic              at_last_pass;

  assign wr_next      = wr_cnt_q + 1'b1;
  assign last_win     = len_q - CNT_BW'(FILTER_LEN);
  assign at_last_win  = (win_q == last_win);
  assign at_last_pass = (pass_q == PASS_BW'(NUM_PASSES - 1));

  assign ready_o     = (state_q != REPLAY);
  assign valid_o     = (state_q == REPLAY);
  assign pass_idx_o  = pass_q;
  assign pass_last_o = valid_o & at_last_win;
  assign last_o      = pass_last_o & at_last_pass;
  assign err_short_o = err_short_q;
  assign err_ovf_o   = err_ovf_q;
  assign dbg_state_o = state_q;

  always_comb begin
    data_o = '0;
    if (state_q == REPLAY) begin
      for (int k = 0; k < FILTER_LEN; k++) begin
        data_o[k*VECTOR_BW +: VECTOR_BW] = buf_q[IDX_BW'(win_q + CNT_BW'(k))];
      end
    end
  end

  // Only LOAD writes the buffer, so replay and DRAIN leave the stored frame intact.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < FRAME_LEN; i++) buf_q[i] <= '0;
    end else if (state_q == LOAD && valid_i) begin
      buf_q[wr_cnt_q[IDX_BW-1:0]] <= data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= LOAD;
      wr_cnt_q    <= '0;
      len_q       <= '0;
      win_q       <= '0;
      pass_q      <= '0;
      err_short_q <= 1'b0;
      err_ovf_q   <= 1'b0;
    end else begin
      err_short_q <= 1'b0;
      err_ovf_q   <= 1'b0;
      case (state_q)
        LOAD: begin
          if (valid_i) begin
            if (last_i) begin
              if (wr_next >= CNT_BW'(FILTER_LEN)) begin
                len_q   <= wr_next;
                win_q   <= '0;
                pass_q  <= '0;
                state_q <= REPLAY;
              end else begin
                wr_cnt_q    <= '0;
                err_short_q <= 1'b1;
              end
            end else if (wr_cnt_q == CNT_BW'(FRAME_LEN - 1)) begin
              len_q     <= CNT_BW'(FRAME_LEN);
              err_ovf_q <= 1'b1;
              state_q   <= DRAIN;
            end else begin
              wr_cnt_q <= wr_next;
            end
          end
        end
        DRAIN: begin
          if (valid_i && last_i) begin
            win_q   <= '0;
            pass_q  <= '0;
            state_q <= REPLAY;
          end
        end
        REPLAY: begin
          if (ready_i) begin
            if (!at_last_win) begin
              win_q <= win_q + 1'b1;
            end else if (!at_last_pass) begin
              win_q  <= '0;
              pass_q <= pass_q + 1'b1;
            end else begin
              wr_cnt_q <= '0;
              state_q  <= LOAD;
            end
          end
        end
        default: state_q <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_recycler.sv
// Directed bench for frame_recycler with a window scoreboard fed by a small model.
module tb_frame_recycler;

  localparam int BW         = 8;
  localparam int VECTOR_LEN = 2;
  localparam int FRAME_LEN  = 6;
  localparam int FILTER_LEN = 3;
  localparam int NUM_PASSES = 2;
  localparam int VBW        = VECTOR_LEN * BW;
  localparam int PASS_BW    = 1;
  localparam int DW         = FILTER_LEN * VBW;
  localparam int EW         = DW + PASS_BW + 2;

  // clock/reset
  logic clk = 1'b0;
  logic rst_n_i = 1'b0;
  always #5 clk = ~clk;

  logic [VBW-1:0]     data_i = '0;
  logic               valid_i = 1'b0;
  logic               last_i = 1'b0;
  logic               ready_o;
  logic [DW-1:0]      data_o;
  logic               valid_o;
  logic               ready_i = 1'b1;
  logic [PASS_BW-1:0] pass_idx_o;
  logic               pass_last_o;
  logic               last_o;
  logic               err_short_o;
  logic               err_ovf_o;
  logic [1:0]         dbg_state_o;

  frame_recycler #(
    .BW(BW), .VECTOR_LEN(VECTOR_LEN), .FRAME_LEN(FRAME_LEN),
    .FILTER_LEN(FILTER_LEN), .NUM_PASSES(NUM_PASSES)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n_i), .data_i(data_i), .valid_i(valid_i),
    .last_i(last_i), .ready_o(ready_o), .data_o(data_o), .valid_o(valid_o),
    .ready_i(ready_i), .pass_idx_o(pass_idx_o), .pass_last_o(pass_last_o),
    .last_o(last_o), .err_short_o(err_short_o), .err_ovf_o(err_ovf_o),
    .dbg_state_o(dbg_state_o)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int pop_cnt = 0;
  int valid_cnt = 0;
  int short_cnt = 0;
  int ovf_cnt = 0;
  logic stall_mode = 1'b0;
  logic [EW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    n_tests++;
    n_fail++;
    $display("FAIL %s observed=timeout expected=event", tag);
  endtask

  // model
  function automatic logic [VBW-1:0] vec(input int tag);
    logic [VBW-1:0] v;
    for (int e = 0; e < VECTOR_LEN; e++) v[e*BW +: BW] = 8'(tag + e * 16);
    return v;
  endfunction

  task automatic push_windows(input int first, input int len);
    logic [DW-1:0] d;
    logic          pl;
    for (int p = 0; p < NUM_PASSES; p++) begin
      for (int w = 0; w <= len - FILTER_LEN; w++) begin
        for (int k = 0; k < FILTER_LEN; k++) d[k*VBW +: VBW] = vec(first + w + k);
        pl = (w == len - FILTER_LEN);
        exp_q.push_back({pl && (p == NUM_PASSES - 1), pl, PASS_BW'(p), d});
      end
    end
  endtask

  // downstream ready: constant high, or toggling each cycle in stall mode
  always @(posedge clk) begin
    #1;
    ready_i = stall_mode ? ~ready_i : 1'b1;
  end

  // scoreboard / monitor
  logic          held_valid = 1'b0;
  logic [EW-1:0] held_val;
  always @(negedge clk) begin
    logic [EW-1:0] cur;
    logic [EW-1:0] exp;
    cur = {last_o, pass_last_o, pass_idx_o, data_o};
    if (!rst_n_i) begin
      held_valid = 1'b0;
    end else begin
      if (err_short_o) short_cnt++;
      if (err_ovf_o) ovf_cnt++;
      if (valid_o) valid_cnt++;
      if (held_valid) check("stall_hold", 64'(cur), 64'(held_val));
      held_valid = valid_o && !ready_i;
      held_val = cur;
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_window observed=%h expected=none", cur);
        end else begin
          exp = exp_q.pop_front();
          check("window", 64'(cur), 64'(exp));
        end
        pop_cnt++;
      end
    end
  end

  // driver tasks
  task automatic send_beat(input int tag, input logic last);
    int cyc = 0;
    data_i = vec(tag);
    valid_i = 1'b1;
    last_i = last;
    while (!ready_o && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (cyc >= 100) timeout("ready_o_wait");
    @(posedge clk); #1;
    valid_i = 1'b0;
    last_i = 1'b0;
  endtask

  task automatic send_frame(input int first, input int n);
    for (int i = 0; i < n; i++) send_beat(first + i, i == n - 1);
  endtask

  task automatic wait_empty(input string tag);
    int cyc = 0;
    while (exp_q.size() != 0 && cyc < 200) begin
      @(negedge clk); #2;
      cyc++;
    end
    if (exp_q.size() != 0) begin
      timeout(tag);
      exp_q.delete();
    end
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk); #1;
    check({tag, "_ready"}, 64'(ready_o), 64'(1));
    check({tag, "_valid"}, 64'(valid_o), 64'(0));
    check({tag, "_data"}, 64'(data_o), 64'(0));
  endtask

  initial begin
    int s0;
    int v0;
    int cyc;
    // reset state
    #12;
    check("rst_valid", 64'(valid_o), 64'(0));
    check("rst_data", 64'(data_o), 64'(0));
    check("rst_flags", 64'({pass_idx_o, pass_last_o, last_o, err_short_o, err_ovf_o}), 64'(0));
    #10 rst_n_i = 1'b1;
    @(posedge clk); #1;
    check("rst_ready", 64'(ready_o), 64'(1));

    // full-rate replay of frame 1..5
    push_windows(1, 5);
    send_frame(1, 5);
    wait_empty("drain_basic");
    check_idle("after_basic");

    // same frame with downstream stalls
    stall_mode = 1'b1;
    push_windows(1, 5);
    send_frame(1, 5);
    wait_empty("drain_stall");
    stall_mode = 1'b0;
    check_idle("after_stall");

    // short frame dropped, then minimum-length frame
    s0 = short_cnt;
    v0 = valid_cnt;
    send_frame(1, 2);
    repeat (3) @(negedge clk);
    #1;
    check("short_pulse", 64'(short_cnt - s0), 64'(1));
    check("short_no_valid", 64'(valid_cnt - v0), 64'(0));
    push_windows(1, 3);
    send_frame(1, 3);
    wait_empty("drain_min");
    check_idle("after_min");

    // overflow: beats 7,8 discarded
    s0 = ovf_cnt;
    push_windows(1, 6);
    for (int i = 1; i <= 6; i++) send_beat(i, 1'b0);
    check("ovf_pulse", 64'(err_ovf_o), 64'(1));
    send_beat(7, 1'b0);
    check("ovf_drain_ready", 64'(ready_o), 64'(1));
    send_beat(8, 1'b1);
    wait_empty("drain_ovf");
    check("ovf_count", 64'(ovf_cnt - s0), 64'(1));
    check_idle("after_ovf");

    // reset in the middle of a replay
    push_windows(1, 5);
    s0 = pop_cnt;
    send_frame(1, 5);
    cyc = 0;
    while (pop_cnt < s0 + 2 && cyc < 100) begin
      @(negedge clk); #2;
      cyc++;
    end
    if (pop_cnt < s0 + 2) timeout("mid_replay_wait");
    #1 rst_n_i = 1'b0;
    #1;
    check("midrst_valid", 64'(valid_o), 64'(0));
    check("midrst_data", 64'(data_o), 64'(0));
    check("midrst_flags", 64'({pass_idx_o, pass_last_o, last_o}), 64'(0));
    exp_q.delete();
    @(negedge clk);
    #2 rst_n_i = 1'b1;
    @(posedge clk); #1;
    push_windows(7, 3);
    send_frame(7, 3);
    wait_empty("drain_after_rst");
    check_idle("after_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
